// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: RV32 instruction decode stage with register file,
// control/immediate decode, load-use hazard stall and an ID/EX output register.
// Optional build macro WB_BYPASS_EN: forwards a same-cycle write-back into the
// captured operands (x0 excluded). Undefined, operands show pre-edge contents.
module id_stage_pipelined #(
  parameter int XLEN  = 8,
  parameter int NREGS = 32,
  parameter int IMM_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instruction,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ex_ready,
  output logic             out_valid,
  output logic             out_branch,
  output logic             out_mem_read,
  output logic             out_mem_to_reg,
  output logic             out_mem_write,
  output logic             out_alu_src,
  output logic             out_reg_write,
  output logic [1:0]       out_alu_op,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_rs1_data,
  output logic [XLEN-1:0]  out_rs2_data,
  output logic [4:0]       out_rd,
  output logic [IMM_W-1:0] out_imm,
  output logic [9:0]       out_funct
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_BUBBLE = 1'b1;

  // Register index is writable/readable only for x1..x(NREGS-1)
  function automatic logic idx_ok(input logic [4:0] idx);
    return (idx != 5'd0) && (32'(idx) < NREGS);
  endfunction

  logic [NREGS-1:0][XLEN-1:0] r_rf;
  logic [0:0]                 r_state;

  logic             r_valid, r_branch, r_mem_read, r_mem_to_reg, r_mem_write;
  logic             r_alu_src, r_reg_write, r_illegal;
  logic [1:0]       r_alu_op;
  logic [XLEN-1:0]  r_rs1_data, r_rs2_data;
  logic [4:0]       r_rd;
  logic [IMM_W-1:0] r_imm;
  logic [9:0]       r_funct;

  logic [6:0]       w_opcode;
  logic [4:0]       w_rs1, w_rs2, w_rd;
  logic             w_adv, w_haz, w_take;
  logic             w_branch, w_mem_read, w_mem_to_reg, w_mem_write;
  logic             w_alu_src, w_reg_write, w_illegal;
  logic [1:0]       w_alu_op;
  logic [11:0]      w_imm12;
  logic [IMM_W-1:0] w_imm;
  logic [XLEN-1:0]  w_rs1_data, w_rs2_data;

  assign w_opcode = in_instruction[6:0];
  assign w_rd     = in_instruction[11:7];
  assign w_rs1    = in_instruction[19:15];
  assign w_rs2    = in_instruction[24:20];

  // Output register can move when empty or when execute takes it; a load in
  // the output register blocks any instruction that names its rd as a source
  assign w_adv  = ~r_valid | ex_ready;
  assign w_haz  = r_valid & r_mem_read & (r_rd != 5'd0) &
                  ((r_rd == w_rs1) | (r_rd == w_rs2));
  assign in_ready = w_adv & ~w_haz & ~reset;
  assign w_take   = in_valid & in_ready & ~flush;

  // Control decode from the opcode; unknown opcodes flag illegal
  always_comb begin
    w_branch     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_op     = 2'b00;
    w_illegal    = 1'b0;
    w_imm12      = 12'd0;
    case (w_opcode)
      OP_R: begin
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
      end
      OP_I: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
        w_imm12     = in_instruction[31:20];
      end
      OP_LOAD: begin
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 1'b1;
        w_reg_write  = 1'b1;
        w_imm12      = in_instruction[31:20];
      end
      OP_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm12     = {in_instruction[31:25], in_instruction[11:7]};
      end
      OP_BRANCH: begin
        w_branch = 1'b1;
        w_alu_op = 2'b01;
        w_imm12  = {in_instruction[31], in_instruction[7],
                    in_instruction[30:25], in_instruction[11:8]};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Fit the 12-bit immediate to IMM_W: sign-extend when wider, truncate when narrower
  generate
    if (IMM_W > 12) begin : g_imm_sext
      assign w_imm = {{(IMM_W-12){w_imm12[11]}}, w_imm12};
    end else if (IMM_W == 12) begin : g_imm_eq
      assign w_imm = w_imm12;
    end else begin : g_imm_trunc
      assign w_imm = w_imm12[IMM_W-1:0];
    end
  endgenerate

  // Operand read; x0 and out-of-range indices read as zero
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (idx_ok(w_rs1)) w_rs1_data = r_rf[w_rs1[AW-1:0]];
    if (idx_ok(w_rs2)) w_rs2_data = r_rf[w_rs2[AW-1:0]];
`ifdef WB_BYPASS_EN
    if (wb_en && idx_ok(w_rs1) && (wb_rd == w_rs1)) w_rs1_data = wb_data;
    if (wb_en && idx_ok(w_rs2) && (wb_rd == w_rs2)) w_rs2_data = wb_data;
`endif
  end

  // Register file write; independent of stall and flush
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rf <= '0;
    end else if (wb_en && idx_ok(wb_rd)) begin
      r_rf[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  // ID/EX register: flush wins, otherwise load or bubble on advance, else hold
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_branch     <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_alu_op     <= 2'b00;
      r_illegal    <= 1'b0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_rd         <= 5'd0;
      r_imm        <= '0;
      r_funct      <= 10'd0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid <= w_take;
      if (w_take) begin
        r_branch     <= w_branch;
        r_mem_read   <= w_mem_read;
        r_mem_to_reg <= w_mem_to_reg;
        r_mem_write  <= w_mem_write;
        r_alu_src    <= w_alu_src;
        r_reg_write  <= w_reg_write;
        r_alu_op     <= w_alu_op;
        r_illegal    <= w_illegal;
        r_rs1_data   <= w_rs1_data;
        r_rs2_data   <= w_rs2_data;
        r_rd         <= w_rd;
        r_imm        <= w_imm;
        r_funct      <= {in_instruction[31:25], in_instruction[14:12]};
      end
    end
  end

  // Stall tracking: BUBBLE marks the single empty slot after a load-use stall
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
    end else if (flush) begin
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN:    if (w_adv && w_haz && in_valid) r_state <= S_BUBBLE;
        default:  r_state <= S_RUN;
      endcase
    end
  end

  assign out_valid      = r_valid;
  assign out_branch     = r_branch;
  assign out_mem_read   = r_mem_read;
  assign out_mem_to_reg = r_mem_to_reg;
  assign out_mem_write  = r_mem_write;
  assign out_alu_src    = r_alu_src;
  assign out_reg_write  = r_reg_write;
  assign out_alu_op     = r_alu_op;
  assign out_illegal    = r_illegal;
  assign out_rs1_data   = r_rs1_data;
  assign out_rs2_data   = r_rs2_data;
  assign out_rd         = r_rd;
  assign out_imm        = r_imm;
  assign out_funct      = r_funct;

endmodule
